// File: rtl/debug_link_master.sv
// Host-side debug link initiator: sends one command byte via Tx, then assembles RESP_BYTES Rx bytes into resp_word_o.
// Optional build macro ECHO_CHECK_EN: expect and verify a command echo before the payload.
module debug_link_master #(
   parameter int D_BIT       = 7,
   parameter int RESP_BYTES  = 4,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              cmd_valid_i,
   input  logic [D_BIT:0]                    cmd_byte_i,
   output logic                              cmd_ready_o,
   output logic                              busy_o,
   output logic [D_BIT:0]                    tx_dato_in_o,
   output logic                              tx_start_o,
   input  logic                              tx_done_i,
   input  logic [D_BIT:0]                    rx_dato_out_i,
   input  logic                              rx_done_i,
   output logic [(D_BIT+1)*RESP_BYTES-1:0]   resp_word_o,
   output logic                              resp_valid_o,
   output logic                              timeout_o,
   output logic                              err_o
);

   localparam int BW = D_BIT + 1;
   localparam int RW = BW * RESP_BYTES;
   localparam int CW = $clog2(RESP_BYTES) + 1;
   localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam bit TO_EN = (TIMEOUT_CYC != 0);
   localparam logic [CW-1:0] LAST = CW'(RESP_BYTES - 1);
   localparam logic [TW-1:0] TMAX = TW'(TO_EN ? TIMEOUT_CYC - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_WAIT_TX, S_RECV, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   tx_byte_q, tx_byte_d;
   logic [RW-1:0]   shadow_q, shadow_d;
   logic [RW-1:0]   resp_q, resp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            timeout_q, timeout_d;
   logic            expired;
`ifdef ECHO_CHECK_EN
   logic            echo_q, echo_d;
   logic            err_q, err_d;
`endif

   // Timer only ever reaches TMAX when enabled; disabled builds saturate instead of wrapping.
   assign expired = TO_EN && (timer_q == TMAX);

   always_comb begin
      state_d   = state_q;
      tx_byte_d = tx_byte_q;
      shadow_d  = shadow_q;
      resp_d    = resp_q;
      cnt_d     = cnt_q;
      timer_d   = timer_q;
      timeout_d = 1'b0;
`ifdef ECHO_CHECK_EN
      echo_d    = echo_q;
      err_d     = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               tx_byte_d = cmd_byte_i;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            timer_d = '0;
            state_d = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            if (tx_done_i) begin
               cnt_d   = '0;
               timer_d = '0;
               state_d = S_RECV;
`ifdef ECHO_CHECK_EN
               echo_d  = 1'b1;
`endif
            end else if (expired) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else if (timer_q != '1) begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_RECV: begin
            if (rx_done_i) begin
               timer_d = '0;
`ifdef ECHO_CHECK_EN
               if (echo_q) begin
                  echo_d = 1'b0;
                  if (rx_dato_out_i != tx_byte_q) begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end
               end else
`endif
               begin
                  shadow_d[int'(cnt_q)*BW +: BW] = rx_dato_out_i;
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q == LAST) begin
                     resp_d  = shadow_d;
                     state_d = S_DONE;
                  end
               end
            end else if (expired) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else if (timer_q != '1) begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         tx_byte_q <= '0;
         shadow_q  <= '0;
         resp_q    <= '0;
         cnt_q     <= '0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
`ifdef ECHO_CHECK_EN
         echo_q    <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         tx_byte_q <= tx_byte_d;
         shadow_q  <= shadow_d;
         resp_q    <= resp_d;
         cnt_q     <= cnt_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
`ifdef ECHO_CHECK_EN
         echo_q    <= echo_d;
         err_q     <= err_d;
`endif
      end
   end

   assign cmd_ready_o  = (state_q == S_IDLE);
   assign busy_o       = (state_q != S_IDLE);
   assign tx_start_o   = (state_q == S_SEND);
   assign tx_dato_in_o = tx_byte_q;
   assign resp_word_o  = resp_q;
   assign resp_valid_o = (state_q == S_DONE);
   assign timeout_o    = timeout_q;
`ifdef ECHO_CHECK_EN
   assign err_o        = err_q;
`else
   assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_debug_link_master.sv
// Directed bench for debug_link_master: vector table of full transactions plus reset, timeout and coincidence sequences.
module tb_debug_link_master;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        cmd_valid_i;
   logic [7:0]  cmd_byte_i;
   logic        cmd_ready_o;
   logic        busy_o;
   logic [7:0]  tx_dato_in_o;
   logic        tx_start_o;
   logic        tx_done_i;
   logic [7:0]  rx_dato_out_i;
   logic        rx_done_i;
   logic [31:0] resp_word_o;
   logic        resp_valid_o;
   logic        timeout_o;
   logic        err_o;

   int n_pass = 0;
   int n_tot  = 0;
   int rv_cnt = 0;
   int to_cnt = 0;
   int er_cnt = 0;

   debug_link_master #(.D_BIT(7), .RESP_BYTES(4), .TIMEOUT_CYC(50)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .cmd_valid_i(cmd_valid_i), .cmd_byte_i(cmd_byte_i),
      .cmd_ready_o(cmd_ready_o), .busy_o(busy_o),
      .tx_dato_in_o(tx_dato_in_o), .tx_start_o(tx_start_o), .tx_done_i(tx_done_i),
      .rx_dato_out_i(rx_dato_out_i), .rx_done_i(rx_done_i),
      .resp_word_o(resp_word_o), .resp_valid_o(resp_valid_o),
      .timeout_o(timeout_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (resp_valid_o) rv_cnt++;
      if (timeout_o)    to_cnt++;
      if (err_o)        er_cnt++;
   end

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] seq;     // bytes in arrival order, first byte in [31:24]
      bit          noise;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [4];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic send_cmd(input logic [7:0] c);
      cmd_valid_i = 1'b1;
      cmd_byte_i  = c;
      chk("cmd_ready_before_accept", cmd_ready_o, 1);
      tick();
      cmd_valid_i = 1'b0;
      chk("tx_start_send", tx_start_o, 1);
      chk("tx_dato_send", tx_dato_in_o, c);
      tick();
      chk("tx_start_single", tx_start_o, 0);
   endtask

   task automatic tx_ack();
      tick();
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      tick();
      rx_done_i     = 1'b1;
      rx_dato_out_i = b;
      tick();
      rx_done_i = 1'b0;
   endtask

   task automatic echo(input logic [7:0] c);
`ifdef ECHO_CHECK_EN
      rx_byte(c);
`else
      if (c === 8'hxx) tick();
`endif
   endtask

   initial begin
      int rv0, to0, er0;
      logic [31:0] prev;
      logic [31:0] seq;

      vecs[0] = '{8'h5A, 32'h11223344, 1'b0, 32'h44332211};
      vecs[1] = '{8'hA5, 32'hFF008001, 1'b1, 32'h018000FF};
      vecs[2] = '{8'h00, 32'hDEADBEEF, 1'b0, 32'hEFBEADDE};
      vecs[3] = '{8'hC3, 32'h01020304, 1'b1, 32'h04030201};

      reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_byte_i = '0;
      tx_done_i = 1'b0; rx_done_i = 1'b0; rx_dato_out_i = '0;
      repeat (3) tick();
      reset_i = 1'b0;
      chk("rst_cmd_ready", cmd_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_tx_start", tx_start_o, 0);
      chk("rst_tx_dato", tx_dato_in_o, 0);
      chk("rst_resp_word", resp_word_o, 0);
      chk("rst_resp_valid", resp_valid_o, 0);
      chk("rst_timeout", timeout_o, 0);

      // reset held 3 clk in the middle of RECV
      send_cmd(8'hE1);
      tx_ack();
      echo(8'hE1);
      rx_byte(8'h55);
      chk("midrecv_busy", busy_o, 1);
      rv0 = rv_cnt; to0 = to_cnt; er0 = er_cnt;
      reset_i = 1'b1;
      repeat (3) tick();
      reset_i = 1'b0;
      tick();
      chk("midrst_cmd_ready", cmd_ready_o, 1);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_resp_word", resp_word_o, 0);
      chk("midrst_tx_dato", tx_dato_in_o, 0);
      chk("midrst_no_pulses", (rv_cnt - rv0) + (to_cnt - to0) + (er_cnt - er0), 0);

      for (int v = 0; v < 4; v++) begin
         rv0 = rv_cnt;
         seq = vecs[v].seq;
         if (vecs[v].noise) begin
            rx_done_i = 1'b1; rx_dato_out_i = 8'h77;
            tick(); tick();
            rx_done_i = 1'b0;
            chk("idle_rx_ignored", cmd_ready_o, 1);
         end
         send_cmd(vecs[v].cmd);
         if (vecs[v].noise) begin
            rx_done_i = 1'b1; rx_dato_out_i = 8'h99;
            cmd_valid_i = 1'b1; cmd_byte_i = ~vecs[v].cmd;
            tick();
            rx_done_i = 1'b0; cmd_valid_i = 1'b0;
            chk("busy_cmd_ignored", tx_dato_in_o, vecs[v].cmd);
         end
         tx_ack();
         echo(vecs[v].cmd);
         for (int i = 0; i < 4; i++) begin
            rx_byte(seq[31-8*i -: 8]);
            if (vecs[v].noise && i == 1) begin
               tx_done_i = 1'b1; cmd_valid_i = 1'b1;
               tick();
               tx_done_i = 1'b0; cmd_valid_i = 1'b0;
            end
         end
         chk("resp_valid", resp_valid_o, 1);
         chk("resp_word", resp_word_o, vecs[v].exp);
         tick();
         chk("resp_valid_single", resp_valid_o, 0);
         chk("done_to_idle", cmd_ready_o, 1);
         chk("resp_valid_pulses", rv_cnt - rv0, 1);
      end

      // timeout 50 clk after the 2nd of only two bytes
      prev = resp_word_o;
      rv0 = rv_cnt;
      send_cmd(8'h3C);
      tx_ack();
      echo(8'h3C);
      rx_byte(8'hAA);
      rx_byte(8'hBB);
      repeat (49) tick();
      chk("timeout_not_early", timeout_o, 0);
      chk("busy_before_timeout", busy_o, 1);
      tick();
      chk("timeout_pulse", timeout_o, 1);
      chk("timeout_idle", cmd_ready_o, 1);
      chk("timeout_resp_held", resp_word_o, prev);
      tick();
      chk("timeout_single", timeout_o, 0);
      chk("timeout_no_resp_valid", rv_cnt - rv0, 0);

      // events coincident with timer == TIMEOUT_CYC-1 win over the timeout
      to0 = to_cnt;
      send_cmd(8'h66);
      repeat (49) tick();
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
      chk("txdone_coincident_busy", busy_o, 1);
      echo(8'h66);
      repeat (49) tick();
      rx_done_i = 1'b1; rx_dato_out_i = 8'h10;
      tick();
      rx_done_i = 1'b0;
      chk("rxdone_coincident_busy", busy_o, 1);
      rx_byte(8'h20);
      rx_byte(8'h30);
      rx_byte(8'h40);
      chk("coincident_resp_valid", resp_valid_o, 1);
      chk("coincident_resp_word", resp_word_o, 32'h40302010);
      chk("coincident_no_timeout", to_cnt - to0, 0);
      tick();

`ifdef ECHO_CHECK_EN
      prev = resp_word_o;
      send_cmd(8'h5A);
      tx_ack();
      rx_byte(8'h5B);
      chk("echo_err_pulse", err_o, 1);
      chk("echo_err_idle", cmd_ready_o, 1);
      chk("echo_err_resp_held", resp_word_o, prev);
      tick();
      chk("echo_err_single", err_o, 0);
`else
      chk("err_never_pulsed", er_cnt, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
